// File: rtl/pipe_ctrl_arbiter_if.sv
// Pipe-control bundle between the hazard/branch/memory sources and the arbiter.
// master = request side (hazard unit, EX, dmem), slave = the arbiter itself.
interface pipe_ctrl_arbiter_if #(
    parameter int unsigned NUM_PIPE_MASKS = 5,
    parameter int unsigned CNT_BITS       = 32
);
    logic [NUM_PIPE_MASKS-1:0] hz_stall0, hz_nop0, hz_flush0;
    logic [NUM_PIPE_MASKS-1:0] hz_stall1, hz_nop1, hz_flush1;
    logic                      branch_taken;
    logic                      dmem_busy;
    logic                      clear_stats;
    logic [NUM_PIPE_MASKS-1:0] stall0, nop0, flush0;
    logic [NUM_PIPE_MASKS-1:0] stall1, nop1, flush1;
    logic                      first;
    logic [CNT_BITS-1:0]       stall_count;
    logic                      mem_timeout;

    modport master (
        output hz_stall0, hz_nop0, hz_flush0, hz_stall1, hz_nop1, hz_flush1,
        output branch_taken, dmem_busy, clear_stats,
        input  stall0, nop0, flush0, stall1, nop1, flush1,
        input  first, stall_count, mem_timeout
    );

    modport slave (
        input  hz_stall0, hz_nop0, hz_flush0, hz_stall1, hz_nop1, hz_flush1,
        input  branch_taken, dmem_busy, clear_stats,
        output stall0, nop0, flush0, stall1, nop1, flush1,
        output first, stall_count, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl_arbiter.sv
// Pipeline-control arbiter: merges hazard masks with branch flushes and dmem stalls,
// owns the lane-order bit and tracks stall cycles / memory timeouts.
module pipe_ctrl_arbiter #(
    parameter int unsigned NUM_PIPE_MASKS   = 5,
    parameter int unsigned BR_SHADOW_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255,
    parameter int unsigned CNT_BITS         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_ctrl_arbiter_if.slave   bus
);
    localparam int unsigned MW        = NUM_PIPE_MASKS;
    localparam int unsigned SHADOW_W  = 4;
    localparam int unsigned MEM_CNT_W = 16;

    localparam logic [MW-1:0] PIPE_REG_PC     = MW'(5'b00001);
    localparam logic [MW-1:0] PIPE_REG_IF_ID  = MW'(5'b00010);
    localparam logic [MW-1:0] PIPE_REG_ID_EX  = MW'(5'b00100);
    localparam logic [MW-1:0] PIPE_REG_EX_MEM = MW'(5'b01000);
    localparam logic [MW-1:0] PIPE_REG_MEM_WB = MW'(5'b10000);

    localparam logic [MW-1:0] BR_FLUSH_MASK  = PIPE_REG_IF_ID | PIPE_REG_ID_EX;
    localparam logic [MW-1:0] MEM_STALL_MASK = PIPE_REG_PC | PIPE_REG_IF_ID |
                                               PIPE_REG_ID_EX | PIPE_REG_EX_MEM;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_BR_SHADOW = 2'd2
    } state_t;

    state_t                 state;
    logic [SHADOW_W-1:0]    shadow_cnt;
    logic [MEM_CNT_W-1:0]   mem_cnt;
    logic                   first_q;
    logic [CNT_BITS-1:0]    stall_count_q;
    logic                   mem_timeout_q;

    logic [MW-1:0]          stall0_c, nop0_c, flush0_c;
    logic [MW-1:0]          stall1_c, nop1_c, flush1_c;
    logic                   split_c;
    logic                   stall_any_c;
    logic [MEM_CNT_W-1:0]   mem_cnt_inc_c;
    logic                   mem_hit_c;

    // Split issue: one lane holds in IF_ID while the other flushes it, so lane order swaps.
    always_comb begin
        split_c = ((bus.hz_stall0[1] & bus.hz_flush1[1]) |
                   (bus.hz_stall1[1] & bus.hz_flush0[1])) &
                  ~(bus.hz_stall0[1] & bus.hz_stall1[1]);
    end

    // Final masks, priority branch > dmem_busy > shadow > hazard pass-through; zero in reset.
    always_comb begin
        stall0_c = '0;
        nop0_c   = '0;
        flush0_c = '0;
        stall1_c = '0;
        nop1_c   = '0;
        flush1_c = '0;
        if (!rst_n) begin
            stall0_c = '0;
        end else if (bus.branch_taken) begin
            flush0_c = BR_FLUSH_MASK;
            flush1_c = BR_FLUSH_MASK;
        end else if (bus.dmem_busy) begin
            stall0_c = MEM_STALL_MASK;
            stall1_c = MEM_STALL_MASK;
            nop0_c   = PIPE_REG_MEM_WB;
            nop1_c   = PIPE_REG_MEM_WB;
        end else if (state == ST_BR_SHADOW) begin
            flush0_c = PIPE_REG_IF_ID;
            flush1_c = PIPE_REG_IF_ID;
        end else begin
            stall0_c = bus.hz_stall0;
            nop0_c   = bus.hz_nop0;
            flush0_c = bus.hz_flush0;
            stall1_c = bus.hz_stall1;
            nop1_c   = bus.hz_nop1;
            flush1_c = bus.hz_flush1;
        end
    end

    always_comb begin
        stall_any_c   = |(stall0_c | stall1_c);
        mem_cnt_inc_c = (mem_cnt == '1) ? mem_cnt : mem_cnt + MEM_CNT_W'(1);
        mem_hit_c     = bus.dmem_busy & ~bus.branch_taken &
                        (mem_cnt_inc_c >= MEM_CNT_W'(MEM_TIMEOUT));
    end

    // Control state, lane order and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            shadow_cnt    <= '0;
            mem_cnt       <= '0;
            first_q       <= 1'b1;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (bus.branch_taken) begin
                state      <= ST_BR_SHADOW;
                shadow_cnt <= SHADOW_W'(BR_SHADOW_CYCLES);
                first_q    <= 1'b1;
                mem_cnt    <= '0;
            end else if (bus.dmem_busy) begin
                state      <= ST_MEM_WAIT;
                shadow_cnt <= '0;
                mem_cnt    <= mem_cnt_inc_c;
            end else if (state == ST_BR_SHADOW) begin
                mem_cnt <= '0;
                if (shadow_cnt <= SHADOW_W'(1)) begin
                    state      <= ST_RUN;
                    shadow_cnt <= '0;
                end else begin
                    shadow_cnt <= shadow_cnt - SHADOW_W'(1);
                end
            end else begin
                state   <= ST_RUN;
                mem_cnt <= '0;
                if (split_c) first_q <= ~first_q;
            end

            if (bus.clear_stats) begin
                stall_count_q <= '0;
                mem_timeout_q <= 1'b0;
            end else begin
                if (stall_any_c && (stall_count_q != '1))
                    stall_count_q <= stall_count_q + CNT_BITS'(1);
                if (mem_hit_c) mem_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall0      = stall0_c;
    assign bus.nop0        = nop0_c;
    assign bus.flush0      = flush0_c;
    assign bus.stall1      = stall1_c;
    assign bus.nop1        = nop1_c;
    assign bus.flush1      = flush1_c;
    assign bus.first       = first_q;
    assign bus.stall_count = stall_count_q;
    assign bus.mem_timeout = mem_timeout_q;

endmodule
